// File: rtl/bus_select_sync_pkg.sv
// Shared defaults and reset constants for the drive-select input conditioning stage.
package bus_select_sync_pkg;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int FILTER_CYCLES_DEF = 8;
  localparam int SEL_W             = 5;
  // All select lines are active low, so the idle vector is all ones.
  localparam logic [SEL_W-1:0] SEL_RST = 5'h1F;

  typedef enum logic {IDLE, SETTLING} filt_state_t;
endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer, one DEPTH-deep chain per bit, presetting to 1 on reset.
module sync_chain #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] ff;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ff <= '1;
    else          ff <= {ff[DEPTH-2:0], d};

  assign q = ff[DEPTH-1];
endmodule

// File: rtl/bus_select_sync.sv
// Synchronizes the raw drive-select bus and only passes a value on once it has
// held steady for FILTER_CYCLES synchronized samples.
module bus_select_sync
  import bus_select_sync_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       BUS_RK11D_L,
  input  logic [3:0] BUS_SEL_DR_L,
  output logic       sync_rk11d_l,
  output logic [3:0] sync_sel_dr_l,
  output logic       sel_changed,
  output logic       sel_stable
);
  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SEL_W-1:0] sync_q;
  filt_state_t      state_q, state_d;
  logic [SEL_W-1:0] cand_q, cand_d, out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             chg_d, stable_d;

  sync_chain #(.WIDTH(SEL_W), .DEPTH(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ({BUS_RK11D_L, BUS_SEL_DR_L}),
    .q       (sync_q)
  );

  // A fresh sample always restarts the wait, even on the edge that would have
  // committed, so skewed or ringing transitions never reach the outputs.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    chg_d    = 1'b0;
    stable_d = (state_q == IDLE) && (sync_q == cand_q);
    if (sync_q != cand_q) begin
      cand_d  = sync_q;
      cnt_d   = '0;
      state_d = SETTLING;
    end else if (state_q == SETTLING) begin
      if (cnt_q == CNT_LAST) begin
        out_d   = cand_q;
        chg_d   = (cand_q != out_q);
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cand_q      <= SEL_RST;
      cnt_q       <= '0;
      out_q       <= SEL_RST;
      sel_changed <= 1'b0;
      sel_stable  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      sel_changed <= chg_d;
      sel_stable  <= stable_d;
    end
  end

  assign {sync_rk11d_l, sync_sel_dr_l} = out_q;
endmodule

// File: tb/tb_bus_select_sync.sv
// Directed and randomized checks of bus_select_sync against a run-length model.
module tb_bus_select_sync;
  localparam int S = 2;
  localparam int F = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       BUS_RK11D_L = 1'b0;
  logic [3:0] BUS_SEL_DR_L = 4'h0;
  logic       sync_rk11d_l;
  logic [3:0] sync_sel_dr_l;
  logic       sel_changed;
  logic       sel_stable;

  bus_select_sync #(.SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .BUS_RK11D_L   (BUS_RK11D_L),
    .BUS_SEL_DR_L  (BUS_SEL_DR_L),
    .sync_rk11d_l  (sync_rk11d_l),
    .sync_sel_dr_l (sync_sel_dr_l),
    .sel_changed   (sel_changed),
    .sel_stable    (sel_stable)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int pulses = 0;
  bit saw_mid = 1'b0;

  // Reference: the raw value seen S edges ago is the sample; an output commits
  // when a run of identical samples reaches exactly F+1 edges.
  logic [4:0] rq[$];
  logic [4:0] run_val, m_out;
  int         run_len;
  logic       m_chg, m_stb;

  task automatic model_reset();
    rq.delete();
    for (int i = 0; i < S; i++) rq.push_back(5'h1F);
    run_val = 5'h1F;
    run_len = 1000000;
    m_out   = 5'h1F;
    m_chg   = 1'b0;
    m_stb   = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] r);
    logic [4:0] s;
    s = rq.pop_front();
    rq.push_back(r);
    m_stb = (s == run_val) && (run_len >= F + 1);
    if (s == run_val) run_len++;
    else begin run_val = s; run_len = 1; end
    m_chg = 1'b0;
    if (run_len == F + 1) begin
      m_chg = (run_val != m_out);
      m_out = run_val;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("out", {3'b0, sync_rk11d_l, sync_sel_dr_l}, {3'b0, m_out});
    chk("sel_changed", {7'b0, sel_changed}, {7'b0, m_chg});
    chk("sel_stable", {7'b0, sel_stable}, {7'b0, m_stb});
    if (sel_changed === 1'b1) pulses++;
    if (sync_sel_dr_l === 4'h6) saw_mid = 1'b1;
  endtask

  task automatic step(input logic [4:0] r);
    {BUS_RK11D_L, BUS_SEL_DR_L} = r;
    @(posedge clock);
    if (reset_n) model_edge(r);
    else model_reset();
    #1;
    check_model();
  endtask

  task automatic hold(input logic [4:0] r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  initial begin
    int n;
    logic [4:0] rv;
    model_reset();

    // Reset held with all-low inputs keeps everything deselected.
    hold(5'h00, 3);
    chk("rst_out", {3'b0, sync_rk11d_l, sync_sel_dr_l}, 8'h1F);
    chk("rst_chg", {7'b0, sel_changed}, 8'h0);
    reset_n = 1'b1;
    pulses = 0;
    hold(5'h00, 15);
    chk("rel_out", {3'b0, sync_rk11d_l, sync_sel_dr_l}, 8'h00);
    chk("rel_pulses", 8'(pulses), 8'd1);

    // Clean select of drive 1, with latency measured from the input change.
    hold(5'h1F, 14);
    pulses = 0;
    n = 0;
    do begin
      step(5'h1D);
      n++;
    end while (sync_sel_dr_l !== 4'hD && n < 50);
    chk("latency", 8'(n), 8'd11);
    hold(5'h1D, 5);
    chk("clean_stable", {7'b0, sel_stable}, 8'h1);
    chk("clean_pulses", 8'(pulses), 8'd1);

    // Short glitch, plus run lengths just below and at the commit threshold.
    hold(5'h1F, 14);
    pulses = 0;
    hold(5'h1E, 5);
    hold(5'h1F, 14);
    chk("glitch_pulses", 8'(pulses), 8'd0);
    chk("glitch_stable", {7'b0, sel_stable}, 8'h1);
    hold(5'h1E, F);
    hold(5'h1F, 14);
    chk("runF_pulses", 8'(pulses), 8'd0);
    hold(5'h1E, F + 1);
    hold(5'h1F, 14);
    chk("runF1_pulses", 8'(pulses), 8'd2);

    // Skewed 4'hE -> 4'h7 transition never shows the intermediate 4'h6.
    hold(5'h1E, 14);
    pulses = 0;
    saw_mid = 1'b0;
    hold(5'h16, 3);
    hold(5'h17, 16);
    chk("skew_out", {4'b0, sync_sel_dr_l}, 8'h7);
    chk("skew_pulses", 8'(pulses), 8'd1);
    chk("skew_mid", {7'b0, saw_mid}, 8'h0);

    // Partial settle then return to the old value: no pulse.
    hold(5'h1F, 14);
    pulses = 0;
    hold(5'h1B, 6);
    hold(5'h1F, 16);
    chk("ret_pulses", 8'(pulses), 8'd0);
    chk("ret_out", {4'b0, sync_sel_dr_l}, 8'hF);

    // Reset mid-settle clears immediately and leaves no pulse behind.
    pulses = 0;
    hold(5'h00, 7);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", {3'b0, sync_rk11d_l, sync_sel_dr_l}, 8'h1F);
    chk("mid_rst_chg", {7'b0, sel_changed}, 8'h0);
    chk("mid_rst_stb", {7'b0, sel_stable}, 8'h0);
    model_reset();
    hold(5'h1F, 2);
    reset_n = 1'b1;
    hold(5'h1F, 16);
    chk("mid_rst_pulses", 8'(pulses), 8'd0);

    // Random bursts of varying length against the model.
    for (int k = 0; k < 150; k++) begin
      rv = 5'($urandom);
      hold(rv, int'($urandom_range(1, 14)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end
endmodule
